// File: rtl/ready_done_sched_pkg.sv
// rtl/ready_done_sched_pkg.sv - state type and default parameters shared by ready_done_sched
package ready_done_sched_pkg;

    localparam int STATE_W         = 2;
    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/ready_done_sched_rr_picker.sv
// rtl/ready_done_sched_rr_picker.sv - round-robin winner selection starting after last_grant
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    // Walk the offsets from farthest to nearest so the nearest set bit is the last write.
    always_comb begin : pick
        logic [IDX_W-1:0] v_idx;
        v_idx    = '0;
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            v_idx = IDX_W'((int'(i_last_grant) + k) % N_REQ);
            if (i_req[v_idx]) begin
                o_winner = v_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ready_done_sched.sv
// rtl/ready_done_sched.sv - round-robin scheduler sharing one ready/done unit among N_REQ requesters
// Optional WAIT abort after TIMEOUT cycles: define READY_DONE_SCHED_TIMEOUT_EN.
module ready_done_sched
    import ready_done_sched_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_unit_ready,
    input  logic             i_unit_output,
    input  logic             i_unit_done,
    output logic [N_REQ-1:0] o_resp_valid,
    output logic             o_resp_data,
    output logic             o_timeout
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_winner;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             r_result;

`ifdef READY_DONE_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] r_timer;
    logic             r_timeout;
    logic             w_expired;

    assign w_expired = (r_timer == TMR_W'(TIMEOUT));
    assign o_timeout = (r_state == ST_RESP) && r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign o_timeout        = 1'b0;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_pick),
        .o_any        (w_any)
    );

    always_comb begin
        w_next_state = r_state;
        o_grant      = '0;
        o_unit_ready = 1'b0;
        o_resp_valid = '0;
        o_resp_data  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_unit_ready      = 1'b1;
                o_grant[r_winner] = 1'b1;
                w_next_state      = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_unit_done) begin
                    w_next_state = ST_RESP;
                end
`ifdef READY_DONE_SCHED_TIMEOUT_EN
                else if (w_expired) begin
                    w_next_state = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                o_resp_valid[r_winner] = 1'b1;
                o_resp_data            = r_result;
                w_next_state           = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_winner     <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_result     <= 1'b0;
`ifdef READY_DONE_SCHED_TIMEOUT_EN
            r_timer      <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any) begin
                r_winner <= w_pick;
            end
            if (r_state == ST_WAIT && i_unit_done) begin
                r_result <= i_unit_output;
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_winner;
            end
`ifdef READY_DONE_SCHED_TIMEOUT_EN
            // Timer reads 0 on the first WAIT cycle; done beats expiry when both arrive together.
            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == ST_WAIT) begin
                if (i_unit_done) begin
                    r_timeout <= 1'b0;
                end else if (w_expired) begin
                    r_timeout <= 1'b1;
                    r_result  <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: doc/ready_done_sched.md
READY_DONE_SCHED -- requirements
Module: ready_done_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one ready/done unit (2..16).
REQ-002 Parameter TIMEOUT, default 64: WAIT-cycle limit before abort (used only with the configuration macro).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  N_REQ  level request per requester; bit i high means requester i wants one job.
REQ-006 grant  out  N_REQ  one-hot, one-cycle pulse marking the requester whose job is being issued.
REQ-007 unit_ready  out  1  drives the shared unit's ready input; one-cycle start pulse.
REQ-008 unit_output  in  1  result bit from the shared unit.
REQ-009 unit_done  in  1  completion strobe from the shared unit.
REQ-010 resp_valid  out  N_REQ  one-hot, one-cycle pulse returning a result to the granted requester.
REQ-011 resp_data  out  1  result bit, valid only while resp_valid is nonzero.
REQ-012 timeout  out  1  high with resp_valid when the job was aborted; otherwise 0.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; all outputs are Moore, decoded from registers.
REQ-014 IDLE: if req nonzero, latch winner and go to ISSUE; else stay. All outputs 0.
REQ-015 Winner SHALL be the first set req bit searching upward from (last_grant+1) mod N_REQ, wrapping.
REQ-016 ISSUE: unit_ready=1, grant[winner]=1 for exactly one cycle; next state WAIT unconditionally.
REQ-017 WAIT: unit_ready=0; on unit_done=1 capture unit_output into the result register and go to RESP.
REQ-018 unit_done during IDLE, ISSUE or RESP SHALL be ignored.
REQ-019 RESP: resp_valid[winner]=1, resp_data=captured bit for one cycle; last_grant<=winner; next state IDLE.
REQ-020 Latency: req high in cycle 0 gives grant in cycle 1; unit_done in cycle d gives resp_valid in cycle d+1.
REQ-021 Minimum job period SHALL be 4 cycles (IDLE, ISSUE, WAIT, RESP); no back-to-back issue without passing IDLE.
REQ-022 Deasserting req[winner] after the winner is latched SHALL NOT cancel the job; the response is still delivered.
REQ-023 A requester holding req continuously SHALL get at most one grant while any other requester is waiting.

Reset
REQ-024 reset SHALL force state IDLE, last_grant=N_REQ-1, result=0, timer=0; all outputs 0 the following cycle.
REQ-025 reset mid-job SHALL abandon the job without issuing resp_valid; a later unit_done is ignored (state IDLE).

Configuration
REQ-026 Macro READY_DONE_SCHED_TIMEOUT_EN defined: a counter clears on entering WAIT, increments each WAIT cycle; at count TIMEOUT without unit_done, go to RESP with timeout=1, resp_data=0.
REQ-027 unit_done and timeout expiry in the same cycle: unit_done wins, timeout=0.
REQ-028 Macro undefined: no counter; WAIT waits indefinitely; timeout output tied to 0.

Structure
REQ-029 Package ready_done_sched_pkg SHALL hold the state enum, state encoding width, and default N_REQ/TIMEOUT constants.
REQ-030 Round-robin selection SHALL be a separate sub-module rr_picker (inputs req, last_grant; output winner index, any).

Verification
REQ-031 Single request: req=0001 at cycle 0, unit_done at cycle 5 with unit_output=1 -> grant=0001 and unit_ready at cycle 1, resp_valid=0001, resp_data=1 at cycle 6.
REQ-032 Fairness: req=1111 held, unit_done 2 cycles after each issue -> grants in order 0001,0010,0100,1000,0001.
REQ-033 Wrap: last grant was 3, req=1001 -> next grant=0001; then req=1001 again -> grant=1000.
REQ-034 Reset during WAIT, then unit_done=1 next cycle -> no resp_valid; all outputs 0; next req=0100 granted normally.
REQ-035 With READY_DONE_SCHED_TIMEOUT_EN, TIMEOUT=8, no unit_done -> resp_valid at WAIT-entry+9, timeout=1, resp_data=0; done on the expiry cycle -> timeout=0.
REQ-036 Spurious unit_done in IDLE and in ISSUE -> no state change, no resp_valid.
